// File: rtl/uart_ack_pkg.sv
// uart_ack_pkg: shared constants and types for the UART command acknowledge path.
//   - Opcode values (top OP_W bits of a command byte).
//   - DDS mode constants that enable the waveform and mode-gated channel commands.
//   - FSM state type for uart_cmd_ack_gen.
//   - Default ACK/NAK response bytes.
package uart_ack_pkg;

  // Opcodes 0..4 are plain register writes; 5..7 carry a checked argument.
  localparam int unsigned OP_FREQ       = 0;
  localparam int unsigned OP_PHASE      = 1;
  localparam int unsigned OP_AMP        = 2;
  localparam int unsigned OP_OFFS       = 3;
  localparam int unsigned OP_SYNC       = 4;
  localparam int unsigned OP_WAVE       = 5;
  localparam int unsigned OP_CHSEL      = 6;
  localparam int unsigned OP_CHSEL_MODE = 7;

  localparam int unsigned MODE_1 = 1;
  localparam int unsigned MODE_2 = 2;

  localparam logic [7:0] ACK_CODE_DEF = 8'h01;
  localparam logic [7:0] NAK_CODE_DEF = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    SEND
  } ack_state_e;

endpackage

// File: rtl/cmd_rule_check.sv
// cmd_rule_check: combinational command validity decoder.
// A command byte is split into op = data[DATA_W-1 -: OP_W] and arg = remaining low bits;
// ok_out is high when the command is legal for the given DDS mode.
// Ports:
//   data_in  [DATA_W-1:0]  command byte
//   mode_in  [MODE_W-1:0]  DDS mode the command is evaluated against
//   ok_out                 1 = accept, 0 = reject
module cmd_rule_check
  import uart_ack_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned OP_W        = 3,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned MODE_W      = 4,
  parameter int unsigned WAVE_MAX_M1 = 5,
  parameter int unsigned WAVE_MAX_M2 = 8
) (
  input  logic [DATA_W-1:0] data_in,
  input  logic [MODE_W-1:0] mode_in,
  output logic              ok_out
);

  localparam int unsigned ARG_W = DATA_W - OP_W;

  localparam logic [ARG_W-1:0] WaveMaxM1 = ARG_W'(WAVE_MAX_M1);
  localparam logic [ARG_W-1:0] WaveMaxM2 = ARG_W'(WAVE_MAX_M2);

  logic [OP_W-1:0]   w_op;
  logic [ARG_W-1:0]  w_arg;
  logic [NUM_CH-1:0] w_ch;
  logic              w_ch_hi_zero;
  logic              w_ch_onehot;
  logic              w_mode1;
  logic              w_mode2;

  assign w_op  = data_in[DATA_W-1 -: OP_W];
  assign w_arg = data_in[ARG_W-1:0];
  assign w_ch  = w_arg[NUM_CH-1:0];

  // Argument bits above the channel field must be clear.
  assign w_ch_hi_zero = (w_arg >> NUM_CH) == '0;
  // Non-zero and clearing the lowest set bit leaves nothing: exactly one bit set.
  assign w_ch_onehot  = (w_ch != '0) && ((w_ch & (w_ch - NUM_CH'(1))) == '0);

  assign w_mode1 = (mode_in == MODE_W'(MODE_1));
  assign w_mode2 = (mode_in == MODE_W'(MODE_2));

  always_comb begin
    ok_out = 1'b0;
    if (w_op <= OP_W'(OP_SYNC)) begin
      ok_out = (data_in != '0);
    end else if (w_op == OP_W'(OP_WAVE)) begin
      if (w_mode1) begin
        ok_out = (w_arg != '0) && (w_arg <= WaveMaxM1);
      end else if (w_mode2) begin
        ok_out = (w_arg != '0) && (w_arg <= WaveMaxM2);
      end
    end else if (w_op == OP_W'(OP_CHSEL)) begin
      ok_out = w_ch_onehot && w_ch_hi_zero;
    end else if (w_op == OP_W'(OP_CHSEL_MODE)) begin
      ok_out = w_ch_onehot && w_ch_hi_zero && (w_mode1 || w_mode2);
    end
  end

endmodule

// File: rtl/uart_cmd_ack_gen.sv
// uart_cmd_ack_gen: registered command validator / ACK-NAK generator between UART RX and TX.
// One command is in flight at a time: IDLE accepts a byte (and samples the mode), EVAL applies
// the rules and registers the response, SEND holds it until TX takes it.
// Ports:
//   clk_in, rst_in           clock, synchronous active-high reset
//   rx_data_in/valid_in      command byte stream; rx_ready_out high only in IDLE
//   mode_in                  DDS mode, sampled together with the accepted byte
//   tx_data_out/valid_out    ACK_CODE or NAK_CODE response; tx_ready_in consumes it
//   last_op_out/last_ok_out  opcode and verdict of the most recently evaluated command
// Build option UART_ACK_ERRCNT_EN adds nak_clr_in and a saturating 16-bit nak_cnt_out.
module uart_cmd_ack_gen
  import uart_ack_pkg::*;
#(
  parameter int unsigned       DATA_W      = 8,
  parameter int unsigned       OP_W        = 3,
  parameter int unsigned       NUM_CH      = 4,
  parameter int unsigned       MODE_W      = 4,
  parameter int unsigned       WAVE_MAX_M1 = 5,
  parameter int unsigned       WAVE_MAX_M2 = 8,
  parameter logic [DATA_W-1:0] ACK_CODE    = DATA_W'(ACK_CODE_DEF),
  parameter logic [DATA_W-1:0] NAK_CODE    = DATA_W'(NAK_CODE_DEF)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [DATA_W-1:0] rx_data_in,
  input  logic              rx_valid_in,
  output logic              rx_ready_out,
  input  logic [MODE_W-1:0] mode_in,
  output logic [DATA_W-1:0] tx_data_out,
  output logic              tx_valid_out,
  input  logic              tx_ready_in,
  output logic [OP_W-1:0]   last_op_out,
  output logic              last_ok_out
`ifdef UART_ACK_ERRCNT_EN
  ,
  input  logic              nak_clr_in,
  output logic [15:0]       nak_cnt_out
`endif
);

  ack_state_e        r_state,   w_state_nxt;
  logic [DATA_W-1:0] r_data,    w_data_nxt;
  logic [MODE_W-1:0] r_mode,    w_mode_nxt;
  logic [DATA_W-1:0] r_tx_data, w_tx_data_nxt;
  logic              r_tx_valid, w_tx_valid_nxt;
  logic [OP_W-1:0]   r_last_op, w_last_op_nxt;
  logic              r_last_ok, w_last_ok_nxt;
  logic              w_rx_ready;
  logic              w_ok;

  cmd_rule_check #(
    .DATA_W      (DATA_W),
    .OP_W        (OP_W),
    .NUM_CH      (NUM_CH),
    .MODE_W      (MODE_W),
    .WAVE_MAX_M1 (WAVE_MAX_M1),
    .WAVE_MAX_M2 (WAVE_MAX_M2)
  ) u_rule_check (
    .data_in (r_data),
    .mode_in (r_mode),
    .ok_out  (w_ok)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_data_nxt     = r_data;
    w_mode_nxt     = r_mode;
    w_tx_data_nxt  = r_tx_data;
    w_tx_valid_nxt = r_tx_valid;
    w_last_op_nxt  = r_last_op;
    w_last_ok_nxt  = r_last_ok;
    w_rx_ready     = 1'b0;
    case (r_state)
      IDLE: begin
        w_rx_ready = 1'b1;
        if (rx_valid_in) begin
          w_data_nxt  = rx_data_in;
          w_mode_nxt  = mode_in;
          w_state_nxt = EVAL;
        end
      end
      EVAL: begin
        w_tx_data_nxt  = w_ok ? ACK_CODE : NAK_CODE;
        w_tx_valid_nxt = 1'b1;
        w_last_op_nxt  = r_data[DATA_W-1 -: OP_W];
        w_last_ok_nxt  = w_ok;
        w_state_nxt    = SEND;
      end
      SEND: begin
        if (tx_ready_in) begin
          w_tx_valid_nxt = 1'b0;
          w_state_nxt    = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state    <= IDLE;
      r_data     <= '0;
      r_mode     <= '0;
      r_tx_data  <= NAK_CODE;
      r_tx_valid <= 1'b0;
      r_last_op  <= '0;
      r_last_ok  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_data     <= w_data_nxt;
      r_mode     <= w_mode_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_valid <= w_tx_valid_nxt;
      r_last_op  <= w_last_op_nxt;
      r_last_ok  <= w_last_ok_nxt;
    end
  end

  assign rx_ready_out = w_rx_ready;
  assign tx_data_out  = r_tx_data;
  assign tx_valid_out = r_tx_valid;
  assign last_op_out  = r_last_op;
  assign last_ok_out  = r_last_ok;

`ifdef UART_ACK_ERRCNT_EN
  logic [15:0] r_nak_cnt;

  // Clear wins over a same-cycle NAK; the count sticks at all-ones.
  always_ff @(posedge clk_in) begin
    if (rst_in || nak_clr_in) begin
      r_nak_cnt <= '0;
    end else if ((r_state == EVAL) && !w_ok && (r_nak_cnt != 16'hFFFF)) begin
      r_nak_cnt <= r_nak_cnt + 16'd1;
    end
  end

  assign nak_cnt_out = r_nak_cnt;
`endif

endmodule

// File: tb/tb_uart_cmd_ack_gen.sv
// Self-checking bench for uart_cmd_ack_gen: directed scenarios plus randomized commands
// compared against a behavioural model of the acceptance rules.
module tb_uart_cmd_ack_gen;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [3:0] mode;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [2:0] last_op;
  logic       last_ok;
`ifdef UART_ACK_ERRCNT_EN
  logic        nak_clr;
  logic [15:0] nak_cnt;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  uart_cmd_ack_gen dut (
    .clk_in       (clk),
    .rst_in       (rst),
    .rx_data_in   (rx_data),
    .rx_valid_in  (rx_valid),
    .rx_ready_out (rx_ready),
    .mode_in      (mode),
    .tx_data_out  (tx_data),
    .tx_valid_out (tx_valid),
    .tx_ready_in  (tx_ready),
    .last_op_out  (last_op),
    .last_ok_out  (last_ok)
`ifdef UART_ACK_ERRCNT_EN
    ,
    .nak_clr_in   (nak_clr),
    .nak_cnt_out  (nak_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference acceptance rules, written directly from the command definitions.
  function automatic bit ref_ok(input int d, input int m);
    int op;
    int arg;
    int ones;
    op   = (d >> 5) & 7;
    arg  = d & 31;
    ones = 0;
    for (int b = 0; b < 4; b++) ones += (arg >> b) & 1;
    if (op <= 4) return d != 0;
    if (op == 5) begin
      if (m == 1) return (arg >= 1) && (arg <= 5);
      if (m == 2) return (arg >= 1) && (arg <= 8);
      return 0;
    end
    if (op == 6) return (ones == 1) && (arg < 16);
    return (ones == 1) && (arg < 16) && ((m == 1) || (m == 2));
  endfunction

  function automatic logic [7:0] ref_resp(input int d, input int m);
    return ref_ok(d, m) ? 8'h01 : 8'hFF;
  endfunction

  // Runs one command with tx_ready high; got=0 if accept or response never appeared.
  // Called and returns #1 after a rising edge.
  task automatic do_cmd(input logic [7:0] d, input logic [3:0] m,
                        output logic [7:0] resp, output bit got);
    bit accepted;
    got      = 1'b0;
    accepted = 1'b0;
    resp     = 8'h00;
    rx_data  = d;
    mode     = m;
    rx_valid = 1'b1;
    tx_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (rx_ready) begin
        @(posedge clk); #1;
        accepted = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    if (accepted) begin
      for (int i = 0; i < 10; i++) begin
        if (tx_valid) begin
          resp = tx_data;
          got  = 1'b1;
          @(posedge clk); #1;
          break;
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (rx_ready !== 1'b1 || tx_valid !== 1'b0 || tx_data !== 8'hFF ||
        last_op !== 3'd0 || last_ok !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: rdy=%b vld=%b data=%h op=%0d ok=%b, want rdy=1 vld=0 data=ff op=0 ok=0",
               rx_ready, tx_valid, tx_data, last_op, last_ok);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_accept_stall();
    tx_ready = 1'b0;
    mode     = 4'd1;
    rx_data  = 8'hA3;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    tests_run++;
    if (rx_ready !== 1'b0 || tx_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_eval: rdy=%b vld=%b, want 0 0", rx_ready, tx_valid);
    end
    @(posedge clk); #1;
    tests_run++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h01 || last_op !== 3'd5 || last_ok !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_resp: vld=%b data=%h op=%0d ok=%b, want 1 01 5 1",
               tx_valid, tx_data, last_op, last_ok);
    end
    // A byte offered while busy must not be taken.
    rx_data  = 8'h00;
    rx_valid = 1'b1;
    mode     = 4'd0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h01 || rx_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL stall_hold[%0d]: vld=%b data=%h rdy=%b, want 1 01 0",
                 i, tx_valid, tx_data, rx_ready);
      end
    end
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (tx_valid !== 1'b0 || rx_ready !== 1'b1 || last_op !== 3'd5 || last_ok !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_release: vld=%b rdy=%b op=%0d ok=%b, want 0 1 5 1",
               tx_valid, rx_ready, last_op, last_ok);
    end
  endtask

  task automatic test_directed_rules();
    logic [7:0] d_tab [12] = '{8'hA7, 8'hA7, 8'hA7, 8'hA0, 8'hA0, 8'hA0,
                               8'hC4, 8'hC6, 8'hD0, 8'hE2, 8'hE2, 8'h21};
    logic [3:0] m_tab [12] = '{4'd1, 4'd2, 4'd3, 4'd1, 4'd2, 4'd3,
                               4'd0, 4'd0, 4'd0, 4'd0, 4'd2, 4'd0};
    logic [7:0] e_tab [12] = '{8'hFF, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                               8'h01, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h01};
    logic [7:0] resp;
    bit         got;
    for (int i = 0; i < 12; i++) begin
      do_cmd(d_tab[i], m_tab[i], resp, got);
      tests_run++;
      if (!got || resp !== e_tab[i] || last_op !== d_tab[i][7:5] ||
          last_ok !== (e_tab[i] == 8'h01)) begin
        tests_failed++;
        $display("FAIL rule cmd=%h mode=%0d: got=%b resp=%h op=%0d ok=%b, want resp=%h op=%0d",
                 d_tab[i], m_tab[i], got, resp, last_op, last_ok, e_tab[i], d_tab[i][7:5]);
      end
    end
  endtask

  task automatic test_zero_and_mode_sample();
    logic [7:0] resp;
    bit         got;
    do_cmd(8'h00, 4'd1, resp, got);
    tests_run++;
    if (!got || resp !== 8'hFF || last_op !== 3'd0 || last_ok !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_byte: got=%b resp=%h op=%0d ok=%b, want ff 0 0",
               got, resp, last_op, last_ok);
    end
    rx_data  = 8'hE1;
    mode     = 4'd1;
    rx_valid = 1'b1;
    tx_ready = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    mode     = 4'd0;
    @(posedge clk); #1;
    tests_run++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h01) begin
      tests_failed++;
      $display("FAIL mode_sample: vld=%b data=%h, want 1 01", tx_valid, tx_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic [3:0] m;
    logic [7:0] resp;
    bit         got;
    for (int i = 0; i < 200; i++) begin
      d = 8'($urandom);
      m = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
      do_cmd(d, m, resp, got);
      tests_run++;
      if (!got || resp !== ref_resp(d, m) || last_op !== d[7:5] || last_ok !== ref_ok(d, m)) begin
        tests_failed++;
        $display("FAIL random cmd=%h mode=%0d: got=%b resp=%h op=%0d ok=%b, want resp=%h ok=%b",
                 d, m, got, resp, last_op, last_ok, ref_resp(d, m), ref_ok(d, m));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] cmds [6];
    int         idx = 0;
    int         nresp = 0;
    int         cycles = 0;
    bit         hs_rx;
    bit         hs_tx;
    int         m;
    m = $urandom_range(0, 3);
    for (int i = 0; i < 6; i++) cmds[i] = 8'($urandom);
    mode     = 4'(m);
    tx_ready = 1'b1;
    rx_data  = cmds[0];
    rx_valid = 1'b1;
    while (nresp < 6 && cycles < 100) begin
      hs_rx = rx_valid && rx_ready;
      hs_tx = tx_valid && tx_ready;
      if (hs_tx) begin
        tests_run++;
        if (tx_data !== ref_resp(cmds[nresp], m)) begin
          tests_failed++;
          $display("FAIL b2b_resp[%0d] cmd=%h mode=%0d: resp=%h, want %h",
                   nresp, cmds[nresp], m, tx_data, ref_resp(cmds[nresp], m));
        end
        nresp++;
      end
      @(posedge clk); #1;
      cycles++;
      if (hs_rx) begin
        idx++;
        if (idx < 6) rx_data = cmds[idx];
        else rx_valid = 1'b0;
      end
    end
    rx_valid = 1'b0;
    tests_run++;
    if (nresp != 6 || cycles != 18) begin
      tests_failed++;
      $display("FAIL b2b_throughput: responses=%0d cycles=%0d, want 6 in 18", nresp, cycles);
    end
  endtask

  task automatic test_reset_mid_send();
    tx_ready = 1'b0;
    mode     = 4'd1;
    rx_data  = 8'hA3;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (tx_valid !== 1'b1 || last_ok !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_pre: vld=%b ok=%b, want 1 1", tx_valid, last_ok);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (tx_valid !== 1'b0 || rx_ready !== 1'b1 || last_ok !== 1'b0 ||
        tx_data !== 8'hFF || last_op !== 3'd0) begin
      tests_failed++;
      $display("FAIL rst_mid_send: vld=%b rdy=%b ok=%b data=%h op=%0d, want 0 1 0 ff 0",
               tx_valid, rx_ready, last_ok, tx_data, last_op);
    end
    rst      = 1'b0;
    tx_ready = 1'b1;
    @(posedge clk); #1;
  endtask

`ifdef UART_ACK_ERRCNT_EN
  task automatic test_errcnt();
    logic [7:0] resp;
    bit         got;
    logic [7:0] seq [4] = '{8'h00, 8'hA0, 8'hC6, 8'h21};
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests_run++;
    if (nak_cnt !== 16'd0) begin
      tests_failed++;
      $display("FAIL errcnt_reset: cnt=%0d, want 0", nak_cnt);
    end
    for (int i = 0; i < 4; i++) do_cmd(seq[i], 4'd1, resp, got);
    tests_run++;
    if (nak_cnt !== 16'd3) begin
      tests_failed++;
      $display("FAIL errcnt_count: cnt=%0d, want 3", nak_cnt);
    end
    rx_data  = 8'h00;
    rx_valid = 1'b1;
    tx_ready = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    nak_clr  = 1'b1;
    @(posedge clk); #1;
    nak_clr  = 1'b0;
    tests_run++;
    if (nak_cnt !== 16'd0 || tx_data !== 8'hFF) begin
      tests_failed++;
      $display("FAIL errcnt_clr_prio: cnt=%0d data=%h, want 0 ff", nak_cnt, tx_data);
    end
    @(posedge clk); #1;
    do_cmd(8'hE0, 4'd1, resp, got);
    tests_run++;
    if (nak_cnt !== 16'd1) begin
      tests_failed++;
      $display("FAIL errcnt_after_clr: cnt=%0d, want 1", nak_cnt);
    end
  endtask
`endif

  initial begin
    rst      = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    mode     = 4'd0;
    tx_ready = 1'b1;
`ifdef UART_ACK_ERRCNT_EN
    nak_clr  = 1'b0;
`endif
    test_reset();
    test_accept_stall();
    test_directed_rules();
    test_zero_and_mode_sample();
    test_random();
    test_back_to_back();
    test_reset_mid_send();
`ifdef UART_ACK_ERRCNT_EN
    test_errcnt();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
